// File: rtl/spi_rx_deserializer_if.sv
// Bundle of frame-control inputs and word-level outputs of the SPI receive deserializer.
// master = SPI pad side / consumer; slave = the deserializer itself.
interface spi_rx_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             rx_busy;
  logic             rx_abort;
  logic             parity_err;

  modport master (
    output load, data_in,
    input  data_out, data_valid, rx_busy, rx_abort, parity_err
  );

  modport slave (
    input  load, data_in,
    output data_out, data_valid, rx_busy, rx_abort, parity_err
  );
endinterface

// File: rtl/spi_rx_deserializer.sv
// Parametrised SPI receive deserializer: WIDTH-bit words, MSB/LSB first, zero-gap streaming.
// Optional trailing parity bit when RX_PARITY_EN is defined.
module spi_rx_deserializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                  spi_clk,
  input logic                  reset,
  spi_rx_deserializer_if.slave rx
);

`ifdef RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             rx_abort_q;
  logic             parity_err_q;

  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word_done;
  logic             par_bad;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shift_next = shift_reg;
    word_done  = shift_reg;
    par_bad    = 1'b0;
    if (MSB_FIRST) shift_next = {shift_reg[WIDTH-2:0], rx.data_in};
    else           shift_next = {rx.data_in, shift_reg[WIDTH-1:1]};
`ifdef RX_PARITY_EN
    // Last frame bit is parity: data bits are already fully shifted in.
    word_done = shift_reg;
    par_bad   = ((^shift_reg) ^ rx.data_in) != PARITY_ODD;
`else
    word_done = shift_next;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      rx_abort_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      rx_abort_q   <= 1'b0;
      parity_err_q <= 1'b0;
      if (rx.load) begin
        if (bit_cnt == LAST_BIT) begin
          data_out_q   <= word_done;
          data_valid_q <= 1'b1;
          parity_err_q <= par_bad;
          shift_reg    <= '0;
          bit_cnt      <= '0;
        end else begin
          shift_reg <= shift_next;
          bit_cnt   <= bit_cnt + CW'(1);
        end
      end else if (bit_cnt != '0) begin
        // Frame enable dropped mid-word: drop the fragment, keep the last good word.
        shift_reg  <= '0;
        bit_cnt    <= '0;
        rx_abort_q <= 1'b1;
      end
    end
  end

`ifndef RX_PARITY_EN
  wire unused_parity_odd = PARITY_ODD;
`endif

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.rx_busy    = (bit_cnt != '0);
  assign rx.rx_abort   = rx_abort_q;
  assign rx.parity_err = parity_err_q;

endmodule
